// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl: exhaustive knapsack subset search over a configurable item table
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   cfg_we/cfg_idx/cfg_value/weight/volume item-table write port (accepted in IDLE only)
//   min_value, max_weight, max_volume      constraint limits, latched on start
//   start, abort                           launch / cancel a search
//   busy, done                             search in progress / one-cycle completion pulse
//   found, best_sel, best_value            best feasible selection seen so far
//   valid_count                            number of feasible selections seen
module knap_search_ctrl #(
   parameter int N_ITEMS = 17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [4:0]         cfg_idx,
   input  logic [4:0]         cfg_value,
   input  logic [4:0]         cfg_weight,
   input  logic [4:0]         cfg_volume,
   input  logic [9:0]         min_value,
   input  logic [9:0]         max_weight,
   input  logic [9:0]         max_volume,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [N_ITEMS-1:0] best_sel,
   output logic [9:0]         best_value,
   output logic [20:0]        valid_count
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_next;
   logic [4:0] r_val [N_ITEMS];
   logic [4:0] r_wt [N_ITEMS];
   logic [4:0] r_vol [N_ITEMS];
   logic [9:0] r_min, r_maxw, r_maxv;
   logic [N_ITEMS-1:0] r_cnt, r_s1_mask, r_best_sel;
   logic [9:0] r_s1_val, r_s1_wt, r_s1_vol, r_best_value;
   logic [9:0] w_sum_val, w_sum_wt, w_sum_vol;
   logic r_s1_vld, r_found, r_done, w_feas, w_better;
   logic [20:0] r_valid_count;

   assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done        = r_done;
   assign found       = r_found;
   assign best_sel    = r_best_sel;
   assign best_value  = r_best_value;
   assign valid_count = r_valid_count;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = start ? S_RUN : S_IDLE;
         S_RUN:   w_next = abort ? S_IDLE : (&r_cnt ? S_DRAIN : S_RUN);
         S_DRAIN: w_next = abort ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // stage 1: attribute sums of the current candidate mask
   always_comb begin
      w_sum_val = '0;
      w_sum_wt  = '0;
      w_sum_vol = '0;
      for (int i = 0; i < N_ITEMS; i++)
         if (r_cnt[i]) begin
            w_sum_val = w_sum_val + {5'd0, r_val[i]};
            w_sum_wt  = w_sum_wt  + {5'd0, r_wt[i]};
            w_sum_vol = w_sum_vol + {5'd0, r_vol[i]};
         end
   end

   // stage 2: an abort on this edge discards the candidate in flight
   assign w_feas   = r_s1_vld && !abort && (r_s1_val >= r_min) && (r_s1_wt <= r_maxw) && (r_s1_vol <= r_maxv);
   // strict compare keeps the earlier (lower) mask on ties since masks arrive in ascending order
   assign w_better = !r_found || (r_s1_val > r_best_value);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            r_val[i] <= '0;
            r_wt[i]  <= '0;
            r_vol[i] <= '0;
         end
         {r_min, r_maxw, r_maxv} <= '0;
         r_cnt         <= '0;
         r_s1_vld      <= 1'b0;
         r_s1_mask     <= '0;
         {r_s1_val, r_s1_wt, r_s1_vol} <= '0;
         r_found       <= 1'b0;
         r_done        <= 1'b0;
         r_best_sel    <= '0;
         r_best_value  <= '0;
         r_valid_count <= '0;
      end else begin
         if (r_state == S_IDLE && cfg_we)
            for (int i = 0; i < N_ITEMS; i++)
               if (cfg_idx == 5'(i)) begin
                  r_val[i] <= cfg_value;
                  r_wt[i]  <= cfg_weight;
                  r_vol[i] <= cfg_volume;
               end
         // registered so the pulse lands one cycle after the DONE state, once results are final
         r_done    <= (r_state == S_DONE);
         r_cnt     <= (r_state == S_RUN) ? r_cnt + N_ITEMS'(1) : '0;
         r_s1_vld  <= (r_state == S_RUN) && !abort;
         r_s1_mask <= r_cnt;
         r_s1_val  <= w_sum_val;
         r_s1_wt   <= w_sum_wt;
         r_s1_vol  <= w_sum_vol;
         if (r_state == S_IDLE && start) begin
            r_min         <= min_value;
            r_maxw        <= max_weight;
            r_maxv        <= max_volume;
            r_found       <= 1'b0;
            r_best_sel    <= '0;
            r_best_value  <= '0;
            r_valid_count <= '0;
         end else if (w_feas) begin
            r_found       <= 1'b1;
            r_valid_count <= r_valid_count + 21'd1;
            if (w_better) begin
               r_best_sel   <= r_s1_mask;
               r_best_value <= r_s1_val;
            end
         end
      end
endmodule

// File: tb/tb_knap_search_ctrl.sv
// tb_knap_search_ctrl: self-checking bench for knap_search_ctrl with N_ITEMS=4
module tb_knap_search_ctrl;
   localparam int NI = 4;
   localparam int LAT = (1 << NI) + 2;
   logic clk = 1'b0;
   logic rst, cfg_we, start, abort;
   logic [4:0] cfg_idx, cfg_value, cfg_weight, cfg_volume;
   logic [9:0] min_value, max_weight, max_volume;
   logic busy, done, found;
   logic [NI-1:0] best_sel;
   logic [9:0] best_value;
   logic [20:0] valid_count;
   int checks = 0, errors = 0;
   int m_v[NI], m_w[NI], m_o[NI];

   always #5 clk = ~clk;

   knap_search_ctrl #(.N_ITEMS(NI)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
      .cfg_weight(cfg_weight), .cfg_volume(cfg_volume), .min_value(min_value),
      .max_weight(max_weight), .max_volume(max_volume), .start(start), .abort(abort),
      .busy(busy), .done(done), .found(found), .best_sel(best_sel),
      .best_value(best_value), .valid_count(valid_count));

   // reference: enumerate every subset directly from the mirrored table
   function automatic void model(input int mn, mw, mo, output int f, sel, bv, cnt);
      f = 0; sel = 0; bv = 0; cnt = 0;
      for (int m = 0; m < (1 << NI); m++) begin
         int sv, sw, so;
         sv = 0; sw = 0; so = 0;
         for (int i = 0; i < NI; i++)
            if (m[i]) begin sv += m_v[i]; sw += m_w[i]; so += m_o[i]; end
         if (sv >= mn && sw <= mw && so <= mo) begin
            cnt++;
            if (f == 0 || sv > bv) begin bv = sv; sel = m; end
            f = 1;
         end
      end
   endfunction

   task automatic wr(input int idx, v, w, o);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_value = 5'(v); cfg_weight = 5'(w); cfg_volume = 5'(o);
      if (idx < NI) begin m_v[idx] = v; m_w[idx] = w; m_o[idx] = o; end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_032();
      wr(0, 10, 5, 5); wr(1, 20, 10, 10); wr(2, 15, 8, 20); wr(3, 5, 1, 1);
   endtask

   // launches a search and returns cycles from the start-sampling edge to done (-1 on timeout)
   task automatic run(input int mn, mw, mo, output int lat);
      @(negedge clk);
      min_value = 10'(mn); max_weight = 10'(mw); max_volume = 10'(mo); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
   endtask

   task automatic test_reset();
      checks++; if ({busy, done, found, best_sel, best_value, valid_count} !== '0) begin errors++; $display("FAIL reset outputs got %h want 0", {busy, done, found, best_sel, best_value, valid_count}); end
   endtask

   task automatic test_basic();
      int lat;
      load_032();
      run(25, 15, 20, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL basic_found got %b want 1", found); end
      checks++; if (best_sel !== 4'b0011) begin errors++; $display("FAIL basic_sel got %b want 0011", best_sel); end
      checks++; if (best_value !== 10'd30) begin errors++; $display("FAIL basic_value got %0d want 30", best_value); end
      checks++; if (valid_count !== 21'd2) begin errors++; $display("FAIL basic_count got %0d want 2", valid_count); end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_done_width got done=%b busy=%b want 0 0", done, busy); end
      checks++; if (best_value !== 10'd30) begin errors++; $display("FAIL basic_hold got %0d want 30", best_value); end
   endtask

   task automatic test_tie();
      int lat;
      for (int i = 0; i < NI; i++) wr(i, 10, 10, 0);
      run(10, 10, 60, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL tie_latency got %0d want %0d", lat, LAT); end
      checks++; if (best_sel !== 4'b0001) begin errors++; $display("FAIL tie_sel got %b want 0001", best_sel); end
      checks++; if (best_value !== 10'd10) begin errors++; $display("FAIL tie_value got %0d want 10", best_value); end
      checks++; if (valid_count !== 21'd4) begin errors++; $display("FAIL tie_count got %0d want 4", valid_count); end
   endtask

   task automatic test_zero();
      int lat;
      for (int i = 0; i < NI; i++) wr(i, 0, 0, 0);
      run(0, 0, 0, lat);
      checks++; if ({found, best_sel, best_value, valid_count} !== {1'b1, 4'b0, 10'd0, 21'd16}) begin errors++; $display("FAIL zero_all got found=%b sel=%b val=%0d cnt=%0d want 1 0000 0 16", found, best_sel, best_value, valid_count); end
      run(1, 0, 0, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
      checks++; if ({found, best_sel, valid_count} !== '0) begin errors++; $display("FAIL zero_none got found=%b sel=%b cnt=%0d want 0 0000 0", found, best_sel, valid_count); end
   endtask

   task automatic test_abort();
      int lat, dn;
      load_032();
      @(negedge clk);
      min_value = 10'd25; max_weight = 10'd15; max_volume = 10'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_run got %b want 1", busy); end
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      dn = 0;
      for (int n = 0; n < 30; n++) begin @(negedge clk); if (done) dn++; end
      checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dn); end
      run(25, 15, 20, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_rerun_latency got %0d want %0d", lat, LAT); end
      checks++; if ({best_sel, best_value, valid_count} !== {4'b0011, 10'd30, 21'd2}) begin errors++; $display("FAIL abort_rerun got sel=%b val=%0d cnt=%0d want 0011 30 2", best_sel, best_value, valid_count); end
   endtask

   task automatic test_ignore();
      int lat;
      @(negedge clk);
      min_value = 10'd25; max_weight = 10'd15; max_volume = 10'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 3) begin
            start = 1'b1; cfg_we = 1'b1; cfg_idx = 5'd0; cfg_value = 5'd31; cfg_weight = 5'd0; cfg_volume = 5'd0;
            min_value = 10'd0; max_weight = 10'd1023; max_volume = 10'd1023;
         end
         if (n == 4) begin start = 1'b0; cfg_we = 1'b0; end
         if (done) begin lat = n; break; end
      end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
      checks++; if ({best_sel, best_value, valid_count} !== {4'b0011, 10'd30, 21'd2}) begin errors++; $display("FAIL ignore_results got sel=%b val=%0d cnt=%0d want 0011 30 2", best_sel, best_value, valid_count); end
   endtask

   task automatic test_random();
      int lat, f, sel, bv, cnt, mn, mw, mo;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NI; i++) wr(i, $urandom_range(31), $urandom_range(31), $urandom_range(31));
         wr($urandom_range(31, NI), $urandom_range(31), $urandom_range(31), $urandom_range(31));
         mn = $urandom_range(60); mw = $urandom_range(80); mo = $urandom_range(80);
         model(mn, mw, mo, f, sel, bv, cnt);
         run(mn, mw, mo, lat);
         checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", it, lat, LAT); end
         checks++; if ({found, best_sel, best_value, valid_count} !== {1'(f), 4'(sel), 10'(bv), 21'(cnt)}) begin errors++; $display("FAIL rand_results[%0d] got found=%b sel=%b val=%0d cnt=%0d want %0d %b %0d %0d", it, found, best_sel, best_value, valid_count, f, 4'(sel), bv, cnt); end
      end
   endtask

   task automatic test_rst_mid();
      int lat, dn;
      load_032();
      @(negedge clk);
      min_value = 10'd25; max_weight = 10'd15; max_volume = 10'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if ({busy, done, found, best_sel, best_value, valid_count} !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", {busy, done, found, best_sel, best_value, valid_count}); end
      for (int i = 0; i < NI; i++) begin m_v[i] = 0; m_w[i] = 0; m_o[i] = 0; end
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int n = 0; n < 25; n++) begin @(negedge clk); if (done) dn++; end
      checks++; if (dn !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", dn); end
      run(0, 0, 0, lat);
      checks++; if ({found, valid_count, best_value} !== {1'b1, 21'd16, 10'd0}) begin errors++; $display("FAIL rst_table_clear got found=%b cnt=%0d val=%0d want 1 16 0", found, valid_count, best_value); end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_idx = '0; cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
      min_value = '0; max_weight = '0; max_volume = '0;
      for (int i = 0; i < NI; i++) begin m_v[i] = 0; m_w[i] = 0; m_o[i] = 0; end
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_tie();
      test_zero();
      test_abort();
      test_ignore();
      test_random();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/knap_search_ctrl.md
KNAP_SEARCH_CTRL -- requirements
Module: knap_search_ctrl

Interface
REQ-001 SHALL have parameter N_ITEMS, default 17, number of selectable items, legal range 1..20.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port cfg_we, input, 1, item-table write strobe.
REQ-005 SHALL have port cfg_idx, input, 5, item index written.
REQ-006 SHALL have ports cfg_value, cfg_weight, cfg_volume, input, 5 each, item attributes.
REQ-007 SHALL have ports min_value, max_weight, max_volume, input, 10 each, constraint limits.
REQ-008 SHALL have port start, input, 1, launch search.
REQ-009 SHALL have port abort, input, 1, cancel search.
REQ-010 SHALL have port busy, output, 1, search in progress.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port found, output, 1, at least one feasible selection seen.
REQ-013 SHALL have port best_sel, output, N_ITEMS, bit i = item i chosen in best selection.
REQ-014 SHALL have port best_value, output, 10, total value of best_sel.
REQ-015 SHALL have port valid_count, output, 21, number of feasible selections seen.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN only.
REQ-017 In IDLE, cfg_we with cfg_idx<N_ITEMS SHALL write the three attributes to table entry cfg_idx; writes in other states or with cfg_idx>=N_ITEMS are ignored.
REQ-018 start in IDLE SHALL latch the three limits, clear found/best_sel/best_value/valid_count, zero the candidate counter, and enter RUN; start outside IDLE is ignored.
REQ-019 RUN SHALL issue one candidate mask per cycle, counting 0 through 2^N_ITEMS-1, then enter DRAIN.
REQ-020 Stage 1 SHALL register the candidate with its total value, weight and volume, each the 10-bit sum of selected item attributes; no overflow is possible for N_ITEMS<=20.
REQ-021 Stage 2 SHALL mark a candidate feasible iff value>=min_value and weight<=max_weight and volume<=max_volume, using latched limits.
REQ-022 A feasible candidate SHALL increment valid_count and set found=1.
REQ-023 A feasible candidate SHALL replace best_sel/best_value only if found was 0 or its value is strictly greater than best_value; ties keep the lower mask.
REQ-024 DRAIN SHALL last exactly one cycle, while the final candidate is evaluated, then enter DONE.
REQ-025 DONE SHALL assert done for exactly one cycle and return to IDLE; results hold until the next start or reset.
REQ-026 done SHALL assert exactly 2^N_ITEMS+2 cycles after the edge that sampled start.
REQ-027 abort in RUN or DRAIN SHALL return to IDLE on the next edge without pulsing done; in-flight candidates are discarded, results keep their partial values; abort has priority over all other transitions.
REQ-028 Limit inputs and table writes changing during RUN/DRAIN SHALL not affect the search in progress.
REQ-029 The empty mask 0 SHALL be evaluated like any other candidate, and is feasible only when min_value=0.

Reset
REQ-030 rst SHALL force IDLE and set busy=0, done=0, found=0, best_sel=0, best_value=0, valid_count=0, counter=0, all table entries=0, all limit latches=0.
REQ-031 rst asserted mid-search SHALL abandon the search immediately, with no done pulse.

Verification (N_ITEMS=4)
REQ-032 Table (v,w,vol): 0:(10,5,5) 1:(20,10,10) 2:(15,8,20) 3:(5,1,1); limits 25/15/20; start -> done 18 cycles later, found=1, best_sel=0011, best_value=30, valid_count=2.
REQ-033 All items (10,10,0); limits 10/10/60 -> best_sel=0001 (tie kept lowest), best_value=10, valid_count=4.
REQ-034 All entries zero; limits 0/0/0 -> valid_count=16, best_sel=0000, best_value=0, found=1; limits 1/0/0 -> found=0, valid_count=0, best_sel=0000.
REQ-035 abort 5 cycles into RUN -> busy=0 next cycle, no done pulse; second start with the REQ-032 setup -> REQ-032 results.
REQ-036 start and cfg_we pulsed during RUN -> both ignored, done timing and results unchanged; rst mid-RUN -> all outputs 0 and table cleared.
